comparator_sweep_checker: RTL and testbench

Self-checking stimulus engine for the 4-bit magnitude comparator. It drives every operand pair onto a comparator's PORT_A/PORT_B inputs and samples that comparator's EQUAL/LESS/HIGHER outputs. It checks each result against an internal unsigned reference, then reports the mismatch count, the first failing vector and a pass/fail verdict. It sits on the output side of the comparator, as a synthesizable counterpart to the simulation bench, for on-board or in-system self-test.

---
 rtl/comparator_sweep_checker.sv | 106 ++++++++++
 tb/tb_comparator_sweep_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_sweep_checker.sv
// Sweeps every {A,B} operand pair through an external magnitude comparator.
// It checks EQUAL/LESS/HIGHER against an unsigned reference and reports the error count and first failing vector.
module comparator_sweep_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               equal,
  input  logic               less,
  input  logic               higher,
  output logic [WIDTH-1:0]   port_a,
  output logic [WIDTH-1:0]   port_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   error_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t               state;
  logic [SW-1:0]        settle_cnt;
  logic [2*WIDTH-1:0]   vec_next;
  logic                 last_vec;
  logic                 mismatch;
  logic [2*WIDTH:0]     error_inc;

  assign vec_next  = {port_a, port_b} + (2*WIDTH)'(1);
  assign last_vec  = &{port_a, port_b};
  assign mismatch  = (equal  != (port_a == port_b)) ||
                     (less   != (port_a <  port_b)) ||
                     (higher != (port_a >  port_b));
  assign error_inc = {{(2*WIDTH){1'b0}}, mismatch};

  // Settle counter paces each vector; the sampling edge also advances the operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      settle_cnt   <= '0;
      port_a       <= '0;
      port_b       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      error_count  <= '0;
      fail_valid   <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_RUN;
            settle_cnt   <= '0;
            port_a       <= '0;
            port_b       <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            error_count  <= '0;
            fail_valid   <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
          end
        end
        ST_RUN: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt  <= '0;
            error_count <= error_count + error_inc;
            if (mismatch && !fail_valid) begin
              fail_valid   <= 1'b1;
              first_fail_a <= port_a;
              first_fail_b <= port_b;
            end
            if (last_vec) begin
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (error_count == '0) && !mismatch;
              port_a <= '0;
              port_b <= '0;
            end else begin
              {port_a, port_b} <= vec_next;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench: behavioural comparators (golden, faulty, pipelined) feed the checker.
// Sweep results are scoreboarded and compared when DONE appears.
module tb_comparator_sweep_checker;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [31:0]      busyCycles;
    logic [31:0]      errCount;
    logic             passExp;
    logic             failValid;
    logic [WIDTH-1:0] ffa;
    logic [WIDTH-1:0] ffb;
  } sweep_exp_t;

  typedef struct {
    string      name;
    int         mode;
    logic       pipe;
    int         pulseAt;
    sweep_exp_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;

  logic             equal, less, higher;
  logic [WIDTH-1:0] port_a, port_b, first_fail_a, first_fail_b;
  logic             busy, done, pass, fail_valid;
  logic [2*WIDTH:0] error_count;

  logic             equal3, less3, higher3;
  logic [WIDTH-1:0] port_a3, port_b3, first_fail_a3, first_fail_b3;
  logic             busy3, done3, pass3, fail_valid3;
  logic [2*WIDTH:0] error_count3;

  int   faultMode = 0;
  logic pipeMode  = 1'b0;
  logic [2:0] stage1 = '0, stage2 = '0, s3a = '0, s3b = '0;

  int checks   = 0;
  int failures = 0;
  sweep_exp_t sb[$];
  vec_t tbl[5];

  always #5 clk = ~clk;

  // mode 0 golden, 1 EQUAL stuck at 0, 2 LESS/HIGHER swapped
  function automatic logic [2:0] cmpModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode);
    logic [2:0] r;
    r = {a == b, a < b, a > b};
    if (mode == 1) r[2] = 1'b0;
    else if (mode == 2) r = {r[2], r[0], r[1]};
    return r;
  endfunction

  always @(posedge clk) begin
    stage1 <= cmpModel(port_a, port_b, faultMode);
    stage2 <= stage1;
    s3a    <= cmpModel(port_a3, port_b3, 0);
    s3b    <= s3a;
  end

  assign {equal, less, higher}    = pipeMode ? stage2 : cmpModel(port_a, port_b, faultMode);
  assign {equal3, less3, higher3} = s3b;

  comparator_sweep_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .equal(equal), .less(less), .higher(higher),
    .port_a(port_a), .port_b(port_b), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .fail_valid(fail_valid),
    .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
  );

  comparator_sweep_checker #(.WIDTH(WIDTH), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .equal(equal3), .less(less3), .higher(higher3),
    .port_a(port_a3), .port_b(port_b3), .busy(busy3), .done(done3), .pass(pass3),
    .error_count(error_count3), .fail_valid(fail_valid3),
    .first_fail_a(first_fail_a3), .first_fail_b(first_fail_b3)
  );

  // A 2-stage comparator sampled after one cycle sees the operands of two vectors earlier
  function automatic sweep_exp_t pipelinedModel();
    sweep_exp_t e;
    logic [2*WIDTH-1:0] h1, h2, v;
    logic [2:0] obs, refBits;
    e = '0;
    e.busyCycles = 256;
    h1 = '0;
    h2 = '0;
    for (int i = 0; i < 256; i++) begin
      v = (2*WIDTH)'(i);
      obs = cmpModel(h2[7:4], h2[3:0], 0);
      refBits = cmpModel(v[7:4], v[3:0], 0);
      if (obs != refBits) begin
        if (e.errCount == 0) begin
          e.failValid = 1'b1;
          e.ffa = v[7:4];
          e.ffb = v[3:0];
        end
        e.errCount = e.errCount + 1;
      end
      h2 = h1;
      h1 = v;
    end
    e.passExp = (e.errCount == 0);
    return e;
  endfunction

  function automatic sweep_exp_t mkExp(input int errs, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    sweep_exp_t e;
    e.busyCycles = 256;
    e.errCount   = 32'(errs);
    e.passExp    = (errs == 0);
    e.failValid  = (errs != 0);
    e.ffa        = a;
    e.ffb        = b;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic waitDone(output int cycles, input int pulseAt, input logic hold);
    cycles = 0;
    while (!done && cycles < 1000) begin
      if (busy) cycles++;
      start = hold || (cycles == pulseAt);
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    checkOutput("done_reached", int'(done), 1);
  endtask

  task automatic checkSweep(input string name, input int cycles, input sweep_exp_t e);
    checkOutput({name, "_busy_cycles"}, cycles, int'(e.busyCycles));
    checkOutput({name, "_error_count"}, int'(error_count), int'(e.errCount));
    checkOutput({name, "_pass"}, int'(pass), int'(e.passExp));
    checkOutput({name, "_fail_valid"}, int'(fail_valid), int'(e.failValid));
    checkOutput({name, "_first_fail_a"}, int'(first_fail_a), int'(e.ffa));
    checkOutput({name, "_first_fail_b"}, int'(first_fail_b), int'(e.ffb));
    checkOutput({name, "_port_a_idle"}, int'(port_a), 0);
    checkOutput({name, "_port_b_idle"}, int'(port_b), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int cycles;
    sweep_exp_t e;
    faultMode = v.mode;
    pipeMode  = v.pipe;
    repeat (4) @(negedge clk);
    sb.push_back(v.exp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cycles, v.pulseAt, 1'b0);
    e = sb.pop_front();
    checkSweep(v.name, cycles, e);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_port_a"}, int'(port_a), 0);
    checkOutput({name, "_port_b"}, int'(port_b), 0);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_done"}, int'(done), 0);
    checkOutput({name, "_pass"}, int'(pass), 0);
    checkOutput({name, "_error_count"}, int'(error_count), 0);
    checkOutput({name, "_fail_valid"}, int'(fail_valid), 0);
    checkOutput({name, "_first_fail_a"}, int'(first_fail_a), 0);
    checkOutput({name, "_first_fail_b"}, int'(first_fail_b), 0);
  endtask

  initial begin
    int cycles;
    sweep_exp_t e;

    tbl[0] = '{name: "golden",      mode: 0, pipe: 1'b0, pulseAt: -1,  exp: mkExp(0, 4'd0, 4'd0)};
    tbl[1] = '{name: "eq_stuck0",   mode: 1, pipe: 1'b0, pulseAt: -1,  exp: mkExp(16, 4'd0, 4'd0)};
    tbl[2] = '{name: "lt_gt_swap",  mode: 2, pipe: 1'b0, pulseAt: -1,  exp: mkExp(240, 4'd0, 4'd1)};
    tbl[3] = '{name: "pipe2_s1",    mode: 0, pipe: 1'b1, pulseAt: -1,  exp: pipelinedModel()};
    tbl[4] = '{name: "start_in_run", mode: 0, pipe: 1'b0, pulseAt: 100, exp: mkExp(0, 4'd0, 4'd0)};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_busy3", int'(busy3), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus(tbl[i]);

    // Abort an erroring sweep at vector (7,3); START asserted during reset must lose
    faultMode = 1;
    pipeMode  = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!(port_a == 4'd7 && port_b == 4'd3) && cycles < 300) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("reached_7_3", int'(port_a == 4'd7 && port_b == 4'd3), 1);
    checkOutput("err_at_7_3", int'(error_count), 7);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    checkAllZero("midrun_reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle_busy", int'(busy), 0);
    checkOutput("post_reset_idle_done", int'(done), 0);
    applyStimulus(tbl[0]);

    // START held across DONE restarts immediately with cleared counts
    faultMode = 1;
    pipeMode  = 1'b0;
    repeat (4) @(negedge clk);
    sb.push_back(tbl[1].exp);
    start = 1'b1;
    @(negedge clk);
    waitDone(cycles, -1, 1'b1);
    e = sb.pop_front();
    checkSweep("held_first", cycles, e);
    sb.push_back(tbl[1].exp);
    @(negedge clk);
    checkOutput("held_restart_busy", int'(busy), 1);
    checkOutput("held_restart_done", int'(done), 0);
    checkOutput("held_restart_errcnt", int'(error_count), 0);
    checkOutput("held_restart_fail_valid", int'(fail_valid), 0);
    waitDone(cycles, -1, 1'b0);
    e = sb.pop_front();
    checkSweep("held_second", cycles, e);

    // Two-stage comparator with three settle cycles per vector
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cycles = 0;
    while (!done3 && cycles < 2000) begin
      if (busy3) cycles++;
      @(negedge clk);
    end
    checkOutput("s3_done", int'(done3), 1);
    checkOutput("s3_busy_cycles", cycles, 768);
    checkOutput("s3_pass", int'(pass3), 1);
    checkOutput("s3_error_count", int'(error_count3), 0);
    checkOutput("s3_fail_valid", int'(fail_valid3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
